// File: rtl/y86_dmem_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder and its initiator.
package y86_dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DEFAULT_MEM_BYTES = 2048;
  localparam int WORD_W            = 64;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;
endpackage

// File: rtl/y86_dmem_array.sv
// Byte-addressed storage with one 8-byte little-endian read port and one write port.
module y86_dmem_array
  import y86_dmem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic                         clk_i,
  input  logic                         we,
  input  logic [$clog2(MEM_BYTES)-1:0] addr,
  input  logic [WORD_W-1:0]            wdata,
  output logic [WORD_W-1:0]            rdata
);
  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  // Byte lane b lives at addr+b; callers only enable writes for in-range words.
  for (genvar b = 0; b < 8; b++) begin : gLane
    logic [AW-1:0] laneAddr;
    assign laneAddr           = addr + AW'(b);
    assign rdata[8*b +: 8]    = mem[laneAddr];
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 8; b++) mem[addr + AW'(b)] <= wdata[8*b +: 8];
    end
  end
endmodule

// File: rtl/y86_dmem_responder.sv
// Memory-side responder: one outstanding 64-bit access, fixed latency, bounds check.
// Define DMEM_ALIGN_CHECK_EN to also reject addresses that are not 8-byte aligned.
module y86_dmem_responder
  import y86_dmem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [WORD_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WORD_W-1:0] resp_rdata_o,
  output logic              resp_error_o,
  output logic [15:0]       err_count_o
);
  localparam int AW = $clog2(MEM_BYTES);

  state_t            state;
  logic [3:0]        cnt;
  logic              accept, inRange, accErr, arrWe;
  logic [WORD_W-1:0] arrRdata;

  assign accept  = (state == IDLE) && req_valid_i;
  // Full-width compare so huge addresses never alias into the array.
  assign inRange = req_addr_i <= 64'(MEM_BYTES - 8);
`ifdef DMEM_ALIGN_CHECK_EN
  assign accErr  = !inRange || (req_addr_i[2:0] != 3'd0);
`else
  assign accErr  = !inRange;
`endif
  assign arrWe   = !rst_i && accept && req_write_i && !accErr;

  y86_dmem_array #(.MEM_BYTES(MEM_BYTES)) uArray (
    .clk_i (clk_i),
    .we    (arrWe),
    .addr  (req_addr_i[AW-1:0]),
    .wdata (req_wdata_i),
    .rdata (arrRdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_error_o <= 1'b0;
      err_count_o  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          resp_rdata_o <= (!req_write_i && !accErr) ? arrRdata : '0;
          resp_error_o <= accErr;
          if (accErr && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
          req_ready_o  <= 1'b0;
          if (LATENCY == 1) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
          end
        end
        RESP: if (resp_ready_i) begin
          state        <= IDLE;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/y86_dmem_responder.md
Name: y86_dmem_responder

Overview:
- Data-memory responder for the Y86-64 core.
- It is the memory-side end of the request/response interface driven by the memory access stage. It services one 64-bit load or store at a time.
- Configurable access latency, little-endian byte storage, bounds checking and a response channel with backpressure.
- Sits between the memory access stage (initiator) and the data storage; the stage derives valM and dmem_error from its response.

Parameters:
- MEM_BYTES, 2048: data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- LATENCY, 2: cycles from request acceptance to resp_valid_o assertion; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-high
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_write_i  input  1  1 = store (rmmovq/call/pushq), 0 = load (mrmovq/ret/popq)
- req_addr_i  input  64  byte address (valE, or valA for ret/popq)
- req_wdata_i  input  64  store data (valA, or valP for call)
- resp_valid_o  output  1  response present
- resp_ready_i  input  1  initiator accepts response
- resp_rdata_o  output  64  load data, little-endian; 0 for stores and errored accesses
- resp_error_o  output  1  access was out of bounds (or misaligned, see the optional feature)
- err_count_o  output  16  saturating count of errored accesses

Behaviour:
- Reset (rst_i=1 at a rising edge) has these effects:
  - The state machine goes to IDLE.
  - req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_error_o=0, err_count_o=0, latency counter=0.
  - Memory array contents are not reset.
- States:
  - IDLE: req_ready_o=1.
    - On req_valid_i&req_ready_o the request is accepted at that edge. A store commits to the array at this same edge; a load captures its 8 bytes at this same edge.
    - If LATENCY==1 go to RESP, otherwise go to WAIT with the counter set to LATENCY-1.
  - WAIT: req_ready_o=0. Decrement the counter each cycle; when the counter reaches 1, go to RESP on the next edge. resp_valid_o rises exactly LATENCY cycles after the accept edge.
  - RESP: resp_valid_o=1; data and error are held stable. On resp_ready_i=1, go to IDLE; resp_valid_o=0 from the next cycle.
- Throughput: a new request can only be accepted in IDLE, so at most one access is outstanding. There is no accept in the same cycle as the RESP handshake; the next accept is at the earliest one cycle after the response completes.
- Bounds: the access is in range iff req_addr_i <= MEM_BYTES-8, compared on the full 64-bit value with no truncation.
  - Out of range: store is suppressed (no byte modified), load returns rdata=0, resp_error_o=1.
  - err_count_o increments once per errored access at the accept edge and saturates at 0xFFFF.
- Byte order: byte addr+0 = data[7:0] … byte addr+7 = data[63:56]. Unaligned in-range accesses are legal unless the optional feature is enabled.
- Read-after-write: a load accepted after a store to overlapping bytes returns the new data.
- Reset mid-operation (WAIT or RESP): return to IDLE and drop the pending response. A store accepted before the reset remains committed.
- Inputs are ignored outside IDLE. req_* are sampled only at the accept edge.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined: req_addr_i[2:0]!=0 is also an error. Such an access behaves exactly as out of range: no write, rdata=0, resp_error_o=1, err_count_o increments.
- When undefined: unaligned in-range accesses complete normally.

Decomposition:
- Shared package y86_dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the default MEM_BYTES;
  - the word width constant (64);
  - the Y86 icode constants (RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B) for the initiator side.
- One sub-module, y86_dmem_array: byte-array storage with one 8-byte little-endian read port and write port. Its write enable is already gated by the bounds check.
- The state machine, counter and error logic stay in the top level.

Test Plan:
- Store 0xDEADBEEFCAFEBABE @0x10, then load @0x10, resp_ready_i=1, LATENCY=2 -> resp_valid_o exactly 2 cycles after each accept; rdata=0xDEADBEEFCAFEBABE; error=0.
- Load @0x900 (MEM_BYTES=2048) -> resp_error_o=1, rdata=0, err_count_o=1. Store @0x900 with 0xFF.. -> error=1, and a subsequent load @0x7F8 is unchanged.
- Store 0x1122334455667788 @0x7F8 -> error=0; byte 0x7FF=0x11. Load @0x7F9 -> error=1. Load @0xFFFFFFFFFFFFFFF8 -> error=1 (no wrap).
- Stores 0xAA..AA@0x40, 0xBB..BB@0x48, 0xCC..CC@0x50, then loads in order -> each returns its value. Unaligned load @0x44 (feature off) -> 0xBBBBBBBBAAAAAAAA.
- Hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o/rdata stable and req_ready_o=0 throughout. Assert rst_i during WAIT -> next cycle IDLE, resp_valid_o never rises.
- With DMEM_ALIGN_CHECK_EN defined: load @0x44 -> error=1, rdata=0. Load @0x48 -> error=0.
